// File: rtl/ahb_pixel_fifo_slave_pkg.sv
// Shared constants for the AHB pixel FIFO slave: register indices, bit
// positions inside CTRL/STATUS, HTRANS encodings and the data-phase record.
package ahb_pixel_fifo_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_UDF_BIT   = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    // What the address phase captured for use in the following data phase.
    typedef struct packed {
        logic       valid;
        logic       write;
        logic [1:0] addr;
    } dphase_t;

endpackage

// File: rtl/ahb_pixel_fifo_slave_if.sv
// AHB-Lite slave-side bus bundle between the MSS master and the pixel FIFO.
interface ahb_pixel_fifo_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_pixel_fifo_slave_fifo.sv
// Plain synchronous FIFO with a combinational head. Callers must not push
// while full without a pop, nor pop while empty; flush beats push and pop.
module pix_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
endmodule

// File: rtl/ahb_pixel_fifo_slave.sv
// AHB-Lite slave exposing a pixel FIFO to firmware: CTRL/STATUS/DATA/LEVEL
// registers, sticky overflow/underflow flags and a level interrupt.
module ahb_pixel_fifo_slave
    import ahb_pixel_fifo_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int DEPTH     = 16,
    parameter int IRQ_LEVEL = 8
) (
    input  logic                 SYSCLK,
    input  logic                 SYSRESET,
    ahb_pixel_fifo_slave_if.slave bus,
    input  logic                 pix_valid,
    input  logic [PIX_W-1:0]     pix_data,
    output logic                 irq
);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    IRQ_LVL = (AW+1)'(IRQ_LEVEL);

    // Handshake: a transfer is accepted on the edge where HSEL, HREADY and a
    // NONSEQ/SEQ HTRANS are all high; its data phase is the next cycle and
    // always completes in that cycle because HREADYOUT is permanently 1.
    dphase_t          dp;
    logic             accept;
    logic             rd_acc, wr_acc;
    logic             pop, push, push_req, flush;
    logic             ovf_set, udf_set, ovf_clr, udf_clr, ctrl_wr;
    logic             ovf_next, udf_next;
    logic             enable, overflow, underflow;
    logic [PIX_W-1:0] head;
    logic [AW:0]      count, level_next;
    logic             empty, full;
    logic [31:0]      head_ext;
    logic             unused_bits;

    assign accept = bus.HSEL && bus.HREADY &&
                    (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);

    // Address-phase capture; reset abandons any pending data phase.
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            dp <= '0;
        end else begin
            dp.valid <= accept;
            dp.write <= bus.HWRITE;
            dp.addr  <= bus.HADDR[3:2];
        end
    end

    assign rd_acc   = dp.valid && !dp.write;
    assign wr_acc   = dp.valid &&  dp.write;
    assign flush    = wr_acc && dp.addr == REG_CTRL && bus.HWDATA[CTRL_FLUSH_BIT];
    assign ctrl_wr  = wr_acc && dp.addr == REG_CTRL;
    assign pop      = rd_acc && dp.addr == REG_DATA && !empty;
    assign udf_set  = rd_acc && dp.addr == REG_DATA &&  empty;
    assign push_req = pix_valid && enable;
    // A full FIFO still takes a pixel when the same edge pops one.
    assign push     = push_req && (!full || pop) && !flush;
    assign ovf_set  = push_req && full && !pop && !flush;
    assign ovf_clr  = wr_acc && dp.addr == REG_STATUS && bus.HWDATA[STAT_OVF_BIT];
    assign udf_clr  = wr_acc && dp.addr == REG_STATUS && bus.HWDATA[STAT_UDF_BIT];
    assign ovf_next = ovf_set || (overflow  && !ovf_clr);
    assign udf_next = udf_set || (underflow && !udf_clr);
    assign level_next = flush ? '0 : count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    pix_sync_fifo #(.WIDTH(PIX_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (SYSCLK),
        .rst   (SYSRESET),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (pix_data),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // Control bit, sticky flags and the registered interrupt.
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            enable    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (ctrl_wr) enable <= bus.HWDATA[CTRL_ENABLE_BIT];
            overflow  <= ovf_next;
            underflow <= udf_next;
            irq       <= enable && ((level_next >= IRQ_LVL) || ovf_next);
        end
    end

    // Read mux driven from the registered address; zero outside read phases.
    always_comb begin
        head_ext            = '0;
        head_ext[PIX_W-1:0] = head;
        bus.HRDATA          = '0;
        if (rd_acc) begin
            case (dp.addr)
                REG_CTRL:   bus.HRDATA[CTRL_ENABLE_BIT] = enable;
                REG_STATUS: begin
                    bus.HRDATA[STAT_EMPTY_BIT] = empty;
                    bus.HRDATA[STAT_FULL_BIT]  = full;
                    bus.HRDATA[STAT_OVF_BIT]   = overflow;
                    bus.HRDATA[STAT_UDF_BIT]   = underflow;
                end
                REG_DATA:   bus.HRDATA = empty ? '0 : head_ext;
                default:    bus.HRDATA[AW:0] = count;
            endcase
        end
    end

    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;

    assign unused_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HSIZE, bus.HWDATA[31:4]};
endmodule

// File: tb/tb_ahb_pixel_fifo_slave.sv
// Bench for ahb_pixel_fifo_slave: directed register scenarios followed by
// randomized bus/pixel traffic, all compared against a queue-based model.
module tb_ahb_pixel_fifo_slave;
    localparam int DEPTH     = 16;
    localparam int IRQ_LEVEL = 8;

    // ---------------- clock / reset ----------------
    logic SYSCLK = 1'b0;
    logic SYSRESET;
    always #5 SYSCLK = ~SYSCLK;

    ahb_pixel_fifo_slave_if bus();
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       irq;

    ahb_pixel_fifo_slave #(.PIX_W(8), .DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
        .SYSCLK    (SYSCLK),
        .SYSRESET  (SYSRESET),
        .bus       (bus.slave),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .irq       (irq)
    );

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    bit         m_en, m_ovf, m_udf, m_irq;
    bit         m_dpv, m_dpw;
    logic [1:0] m_dpa;

    function automatic logic [31:0] m_read();
        logic [31:0] r;
        r = 32'h0;
        case (m_dpa)
            2'd0: r = {31'h0, m_en};
            2'd1: r = {28'h0, m_udf, m_ovf, mq.size() == DEPTH, mq.size() == 0};
            2'd2: r = (mq.size() > 0) ? {24'h0, mq[0]} : 32'h0;
            default: r = mq.size();
        endcase
        return r;
    endfunction

    always @(posedge SYSCLK) begin : model
        bit rd, wr, pop_try, flush, ovf_set, udf_set, ovf_clr, udf_clr, old_en;
        if (SYSRESET) begin
            mq.delete();
            m_en = 0; m_ovf = 0; m_udf = 0; m_irq = 0;
        end else begin
            rd      = m_dpv && !m_dpw;
            wr      = m_dpv &&  m_dpw;
            pop_try = rd && m_dpa == 2'd2;
            flush   = wr && m_dpa == 2'd0 && bus.HWDATA[1];
            ovf_set = 0;
            udf_set = 0;
            old_en  = m_en;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop_try) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    else udf_set = 1;
                end
                if (old_en && pix_valid) begin
                    if (mq.size() < DEPTH) mq.push_back(pix_data);
                    else ovf_set = 1;
                end
            end
            ovf_clr = wr && m_dpa == 2'd1 && bus.HWDATA[2];
            udf_clr = wr && m_dpa == 2'd1 && bus.HWDATA[3];
            m_ovf   = ovf_set || (m_ovf && !ovf_clr);
            m_udf   = udf_set || (m_udf && !udf_clr);
            if (wr && m_dpa == 2'd0) m_en = bus.HWDATA[0];
            m_irq = old_en && (mq.size() >= IRQ_LEVEL || m_ovf);
        end
        m_dpv = !SYSRESET && bus.HSEL && bus.HTRANS[1] && bus.HREADY;
        m_dpw = bus.HWRITE;
        m_dpa = bus.HADDR[3:2];
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge SYSCLK) begin
        if (run_cmp) begin
            chk("hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
            chk("hresp", {31'h0, bus.HRESP}, 32'h0);
            chk("irq", {31'h0, irq}, {31'h0, m_irq});
            if (m_dpv && !m_dpw) chk("hrdata", bus.HRDATA, m_read());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge SYSCLK);
        @(negedge SYSCLK);
    endtask

    task automatic idle_bus();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'd0;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'h0;
        bus.HREADY = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.HSEL = 1'b1; bus.HTRANS = 2'd2; bus.HWRITE = 1'b0;
        bus.HADDR = {28'h0, a, 2'b00}; bus.HREADY = 1'b1;
        tick();
        idle_bus();
        d = bus.HRDATA;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v,
                             input logic sel = 1'b1, input logic [1:0] tr = 2'd2,
                             input logic rdy = 1'b1);
        bus.HSEL = sel; bus.HTRANS = tr; bus.HWRITE = 1'b1;
        bus.HADDR = {28'h0, a, 2'b00}; bus.HREADY = rdy;
        tick();
        idle_bus();
        bus.HWDATA = v;
        tick();
    endtask

    task automatic push_pix(input logic [7:0] v);
        pix_valid = 1'b1;
        pix_data  = v;
        tick();
        pix_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [31:0] v;
        idle_bus();
        bus.HSIZE  = 3'd2;
        bus.HWDATA = 32'h0;
        pix_valid  = 1'b0;
        pix_data   = 8'h0;
        SYSRESET   = 1'b1;
        @(posedge SYSCLK);
        run_cmp = 1;
        repeat (2) @(posedge SYSCLK);
        @(negedge SYSCLK);
        SYSRESET = 1'b0;

        // 1: reset values
        bus_read(2'd0, d); chk("t1_ctrl", d, 32'h0);
        bus_read(2'd1, d); chk("t1_status", d, 32'h1);
        bus_read(2'd2, d); chk("t1_data_empty", d, 32'h0);
        bus_read(2'd1, d); chk("t1_status_udf", d, 32'h9);
        bus_read(2'd3, d); chk("t1_level", d, 32'h0);

        // 2: ordered drain
        bus_write(2'd1, 32'h8);
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 5; i++) push_pix(8'h10 + 8'(i));
        bus_read(2'd3, d); chk("t2_level", d, 32'h5);
        for (int i = 0; i < 5; i++) begin
            bus_read(2'd2, d); chk("t2_data", d, 32'h10 + i);
        end
        bus_read(2'd1, d); chk("t2_status", d, 32'h1);

        // 3: overflow and interrupt
        for (int i = 0; i < 17; i++) push_pix(8'h20 + 8'(i));
        bus_read(2'd1, d); chk("t3_status", d, 32'h6);
        bus_read(2'd3, d); chk("t3_level", d, 32'd16);
        chk("t3_irq", {31'h0, irq}, 32'h1);
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, d); chk("t3_status_clr", d, 32'h2);
        chk("t3_irq_hold", {31'h0, irq}, 32'h1);

        // 4: read coinciding with push at full; streaming wrap
        for (int i = 0; i <= 20; i++) begin
            if (i >= 1) chk("t4_stream", bus.HRDATA, 32'h20 + i - 1);
            if (i < 20) begin
                bus.HSEL = 1'b1; bus.HTRANS = 2'd2; bus.HWRITE = 1'b0;
                bus.HADDR = 32'h8;
            end else begin
                idle_bus();
            end
            pix_valid = (i >= 1);
            pix_data  = 8'h30 + 8'(i) - 8'd1;
            tick();
        end
        pix_valid = 1'b0;
        bus_read(2'd3, d); chk("t4_level", d, 32'd16);
        bus_read(2'd1, d); chk("t4_status", d, 32'h2);

        // 5: flush with simultaneous pixel
        bus.HSEL = 1'b1; bus.HTRANS = 2'd2; bus.HWRITE = 1'b1; bus.HADDR = 32'h0;
        tick();
        idle_bus();
        bus.HWDATA = 32'h3;
        pix_valid  = 1'b1;
        pix_data   = 8'h55;
        tick();
        pix_valid = 1'b0;
        bus_read(2'd3, d); chk("t5_level", d, 32'h0);
        bus_read(2'd1, d); chk("t5_status", d, 32'h1);
        bus_read(2'd0, d); chk("t5_ctrl", d, 32'h1);

        // 6: ignored address phases
        push_pix(8'hA1);
        push_pix(8'hA2);
        bus_write(2'd0, 32'h2, 1'b1, 2'd1, 1'b1);
        bus_read(2'd0, d); chk("t6_busy_ctrl", d, 32'h1);
        bus_read(2'd3, d); chk("t6_busy_level", d, 32'h2);
        bus_write(2'd0, 32'h2, 1'b0, 2'd2, 1'b1);
        bus_read(2'd0, d); chk("t6_nosel_ctrl", d, 32'h1);
        bus_write(2'd0, 32'h2, 1'b1, 2'd2, 1'b0);
        bus_read(2'd0, d); chk("t6_nordy_ctrl", d, 32'h1);
        bus_read(2'd3, d); chk("t6_level", d, 32'h2);

        // 7: randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            SYSRESET   = ($urandom_range(499) == 0);
            bus.HSEL   = ($urandom_range(3) != 0);
            bus.HTRANS = 2'($urandom_range(3));
            bus.HWRITE = ($urandom_range(2) == 0);
            bus.HREADY = ($urandom_range(7) != 0);
            bus.HADDR  = $urandom;
            if ($urandom_range(1) == 0) bus.HADDR[3:2] = 2'd2;
            v = $urandom;
            if ($urandom_range(15) != 0) v[1] = 1'b0;
            v[0] = ($urandom_range(3) != 0);
            bus.HWDATA = v;
            pix_valid  = ($urandom_range(1) == 0);
            pix_data   = 8'($urandom);
            tick();
        end
        SYSRESET  = 1'b0;
        pix_valid = 1'b0;
        idle_bus();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_pixel_fifo_slave.md
Name: ahb_pixel_fifo_slave

Overview:
- Fabric-side AHB-Lite slave that consumes the MSS master bus (MSSHADDR/MSSHTRANS/MSSHWRITE/MSSHWDATA) and drives MSSHRDATA/MSSHREADY/MSSHRESP.
- Buffers a non-stallable pixel stream from the image-sensor readout logic in a synchronous FIFO.
- Firmware drains the FIFO pixel by pixel through a memory-mapped DATA register.
- Provides control, status and level registers plus an interrupt line to the MSS (F2M_GPI).

Parameters:
- PIX_W, 8, pixel width in bits (1..32).
- DEPTH, 16, FIFO depth; power of two, at least 2.
- IRQ_LEVEL, 8, fill level that raises irq; range 1..DEPTH.

Ports:
- SYSCLK  in  1  fabric clock; also the AHB clock.
- SYSRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address; only [3:2] decoded.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  ignored; all accesses treated as 32-bit.
- HWDATA  in  32  write data, valid in data phase.
- HREADY  in  1  bus ready from the interconnect.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  transfer response; 0 = OKAY.
- pix_valid  in  1  pixel strobe.
- pix_data  in  PIX_W  pixel value.
- irq  out  1  level-sensitive interrupt.

Behaviour:
Clocking and reset:
- One clock, SYSCLK. SYSRESET is synchronous and active-high.
- Reset values: HRDATA=0, HREADYOUT=1, HRESP=0, irq=0, ctrl.enable=0, FIFO empty, overflow=0, underflow=0, data-phase state cleared.
- Reset asserted mid-transfer abandons the transfer; no pop occurs.

Bus protocol:
- Zero wait states: HREADYOUT is tied to 1 and HRESP tied to 0.
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. On that edge the slave registers HADDR[3:2], HWRITE and a valid flag.
- IDLE and BUSY transfers are ignored.
- Data phase is the next cycle. HRDATA is combinational from the registered address and current state, so a read immediately after a write returns the post-write value only for flags updated at the write edge. Register writes take effect at the end of the data phase.

Register map (HADDR[3:2]):
- 0 CTRL (RW): bit0 enable; bit1 flush (write-1, self-clearing, reads 0).
- 1 STATUS: bit0 empty (RO); bit1 full (RO); bit2 overflow (W1C); bit3 underflow (W1C).
- 2 DATA (RO): {zero-extend, head pixel}.
  - A read pops at the end of its data phase.
  - A read while empty returns 0, sets underflow and does not pop.
  - Writes are ignored.
- 3 LEVEL (RO): occupancy count, 0..DEPTH, zero-extended.

FIFO:
- Push when pix_valid & enable.
- If push while full and no pop in the same cycle: pixel dropped, overflow set.
- Push and pop in the same cycle while full: both occur, level unchanged, no overflow.
- Push and pop in the same cycle while empty: the pop is an underflow (returns 0); the push is accepted, so level goes to 1.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is a separate log2(DEPTH)+1-bit counter.
- Flush write: pointers and count return to 0 at the end of the data phase. Flush overrides a simultaneous push and pop. Overflow and underflow are unaffected.
- Disabling does not clear the FIFO; pops remain allowed.
- If overflow and its W1C clear land in the same cycle, set wins.

Interrupt:
- irq registered: irq <= enable & ((level_next >= IRQ_LEVEL) | overflow_next).
- One cycle of latency after the triggering edge.

Decomposition:
- Package ahb_pixel_fifo_pkg holds:
  - register index constants: REG_CTRL=0, REG_STATUS=1, REG_DATA=2, REG_LEVEL=3;
  - CTRL and STATUS bit positions;
  - HTRANS encodings: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- One sub-module, pix_sync_fifo (parameters WIDTH, DEPTH):
  - ports push, pop, flush, din, dout (head, combinational), count, empty, full;
  - no overflow or underflow logic inside.
- The top module contains the AHB decode, registers, flags and irq.

Test Plan:
1. Reset, then read all four registers -> CTRL=0x0, STATUS=0x1, DATA=0x0 (underflow set, so STATUS then reads 0x9), LEVEL=0x0; HREADYOUT=1 and HRESP=0 throughout.
2. Write CTRL=0x1, push pixels 0x10..0x14 -> LEVEL=5. Five DATA reads return 0x10,0x11,0x12,0x13,0x14 in order, then STATUS=0x1.
3. With DEPTH=16 and enable on, push 17 pixels without reading -> STATUS=0x6, LEVEL=16, irq=1. Write STATUS=0x4 -> overflow clears; irq stays 1 because level >= 8.
4. With FIFO full, a DATA read coincides with a push -> no overflow, LEVEL stays 16. Continuous push plus back-to-back NONSEQ reads for more than 16 cycles wraps the pointers and returns the data in order.
5. Flush via CTRL=0x3 in the same data phase as pix_valid=1 -> LEVEL=0, STATUS empty, CTRL reads 0x1.
6. HTRANS=BUSY or HSEL=0 with HWRITE=1 to CTRL -> no state change. An HREADY=0 address phase -> ignored.
